// File: rtl/tmds_channel_decoder_pkg.sv
// Shared definitions for the TMDS channel decoder: control tokens, control
// codes, FSM state encoding and default lock/slip thresholds.
package tmds_channel_decoder_pkg;

    // Control tokens, written bit 9 first (bit 0 is the first bit on the wire).
    localparam logic [9:0] TOKEN_CD00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_CD01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_CD10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_CD11 = 10'b1010101011;

    // Control codes {C1,C0}.
    localparam logic [1:0] CD_00 = 2'b00;
    localparam logic [1:0] CD_01 = 2'b01;
    localparam logic [1:0] CD_10 = 2'b10;
    localparam logic [1:0] CD_11 = 2'b11;

    // Default alignment thresholds. SLIP_WAIT must exceed the 1088-word line.
    localparam int DEFAULT_TOKEN_RUN = 8;
    localparam int DEFAULT_SLIP_WAIT = 2048;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // True when the word is any of the four control tokens.
    function automatic logic is_control_token(input logic [9:0] word);
        return (word == TOKEN_CD00) || (word == TOKEN_CD01) ||
               (word == TOKEN_CD10) || (word == TOKEN_CD11);
    endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational decode of one aligned TMDS word: control-token detection with
// its 2-bit code, plus the 8-bit data decode (inversion then XOR/XNOR chain).
module tmds_word_decode
    import tmds_channel_decoder_pkg::*;
(
    input  logic [9:0] word,
    output logic       is_token,
    output logic [1:0] cd,
    output logic [7:0] data
);

    logic [7:0] d;

    // Token lookup: flag a control token and report its code, 00 otherwise.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        is_token = 1'b1;
        cd       = CD_00;
        case (word)
            TOKEN_CD00: cd = CD_00;
            TOKEN_CD01: cd = CD_01;
            TOKEN_CD10: cd = CD_10;
            TOKEN_CD11: cd = CD_11;
            default:    is_token = 1'b0;
        endcase
    end

    // Data path: undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8).
    always_comb begin
        d       = word[9] ? ~word[7:0] : word[7:0];
        data[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: finds the 10-bit word boundary by hunting for runs
// of control tokens, then decodes aligned words into pixel data or control
// codes. Two pipeline stages: aligned word capture, then decoded outputs.
module tmds_channel_decoder
    import tmds_channel_decoder_pkg::*;
#(
    parameter int TOKEN_RUN = DEFAULT_TOKEN_RUN,
    parameter int SLIP_WAIT = DEFAULT_SLIP_WAIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] tmds_word,
    output logic [7:0] data,
    output logic [1:0] cd,
    output logic       de,
    output logic       locked,
    output logic [3:0] offset
);

    localparam int RUN_W  = $clog2(TOKEN_RUN + 1);
    localparam int IDLE_W = $clog2(SLIP_WAIT + 1);

    logic [9:0]        prev;
    logic [18:0]       stream;
    logic [9:0]        window;
    logic              window_token;
    logic [9:0]        w_q;
    state_t            state;
    logic [RUN_W-1:0]  run;
    logic [IDLE_W-1:0] idle;
    logic              dec_token;
    logic [1:0]        dec_cd;
    logic [7:0]        dec_data;

    // The top raw bit is never inside a window (offset tops out at 9), so it is
    // only carried forward through prev.
    assign stream       = {tmds_word[8:0], prev};
    assign window_token = is_control_token(window);

    // Alignment window: ten consecutive wire bits starting at the current offset.
    always_comb begin
        window = stream[9:0];
        for (int i = 1; i < 10; i++) begin
            if (offset == 4'(i)) window = stream[i +: 10];
        end
    end

    // Stage 1: keep the previous raw word and capture the aligned word.
    always_ff @(posedge clk) begin
        // NOTE: registered state is always written with <= so every flop samples pre-edge values.
        if (reset) begin
            prev <= '0;
            w_q  <= '0;
        end else begin
            prev <= tmds_word;
            w_q  <= window;
        end
    end

    // Alignment FSM: counts token runs to lock, slips or drops lock after a long token-free gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_SEARCH;
            run    <= '0;
            idle   <= '0;
            offset <= '0;
        end else begin
            case (state)
                ST_SEARCH: begin
                    if (window_token) begin
                        idle <= '0;
                        if (run == RUN_W'(TOKEN_RUN - 1)) begin
                            state <= ST_LOCKED;
                            run   <= '0;
                        end else begin
                            run <= run + 1'b1;
                        end
                    end else begin
                        run <= '0;
                        if (idle == IDLE_W'(SLIP_WAIT - 1)) begin
                            idle   <= '0;
                            offset <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
                        end else begin
                            idle <= idle + 1'b1;
                        end
                    end
                end
                default: begin
                    if (window_token) begin
                        idle <= '0;
                    end else if (idle == IDLE_W'(SLIP_WAIT - 1)) begin
                        state <= ST_SEARCH;
                        idle  <= '0;
                        run   <= '0;
                    end else begin
                        idle <= idle + 1'b1;
                    end
                end
            endcase
        end
    end

    tmds_word_decode u_decode (
        .word     (w_q),
        .is_token (dec_token),
        .cd       (dec_cd),
        .data     (dec_data)
    );

    // Stage 2: publish data or control code, gated by the lock state that word produced.
    always_ff @(posedge clk) begin
        if (reset) begin
            data   <= '0;
            cd     <= CD_00;
            de     <= 1'b0;
            locked <= 1'b0;
        end else begin
            locked <= (state == ST_LOCKED);
            data   <= '0;
            cd     <= CD_00;
            de     <= 1'b0;
            if (state == ST_LOCKED) begin
                if (dec_token) begin
                    cd <= dec_cd;
                end else begin
                    de   <= 1'b1;
                    data <= dec_data;
                end
            end
        end
    end

endmodule

// File: doc/tmds_channel_decoder.md
# tmds_channel_decoder

Receive-side counterpart of the HDMI output path. It takes raw 10-bit words for one TMDS channel from an external deserializer, clocked at the pixel clock, and finds the 10-bit word boundary by searching for control tokens. It then decodes each aligned word into 8-bit pixel data, or into a 2-bit control code during blanking. Three instances, one per colour channel, form the front end of the capture/loopback path.

## Interface
Parameters:
- TOKEN_RUN, 8: number of consecutive control tokens required to declare lock.
- SLIP_WAIT, 2048: number of words without any token before the search slips one bit (SEARCH) or lock is dropped (LOCKED). Must exceed the line length of 1088.

Ports:
- clk  in  1  pixel clock. One raw word arrives per cycle.
- reset  in  1  synchronous, active-high.
- tmds_word  in  10  raw, unaligned deserializer word. Bit 0 is the first bit on the wire.
- data  out  8  decoded pixel byte. Valid when de=1.
- cd  out  2  decoded control code {C1,C0}. Valid when de=0 and locked=1.
- de  out  1  data enable. 1 means data holds a pixel.
- locked  out  1  word alignment established.
- offset  out  4  current bit offset of the alignment window, 0..9.

## Operation
- Window: keep the previous raw word in prev. Form stream = {tmds_word, prev} (20 bits). The aligned word is w = stream[offset+9 : offset].
- Control tokens, bit 9 first:
  - 1101010100 → cd 00
  - 0010101011 → cd 01
  - 0101010100 → cd 10
  - 1010101011 → cd 11
- Data decode:
  - d = w[9] ? ~w[7:0] : w[7:0].
  - data[0] = d[0].
  - data[i] = w[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]), for i = 1..7.
- FSM states: SEARCH and LOCKED. Two counters: run (counts to TOKEN_RUN) and idle (counts to SLIP_WAIT).
- SEARCH:
  - Token at w: run+1 and idle cleared. When run reaches TOKEN_RUN, go to LOCKED.
  - Non-token: run cleared and idle+1.
  - idle reaching SLIP_WAIT: offset advances (9 wraps to 0), and idle and run are cleared.
- LOCKED:
  - Any token clears idle. Non-token words increment idle.
  - idle reaching SLIP_WAIT: return to SEARCH with offset unchanged and both counters cleared.
- Simultaneous events: the token check uses the window at the current offset. A new offset first applies to the word formed in the following cycle. A slip and a token can never both take effect in the same cycle.
- Output rules:
  - When not locked: de=0, cd=00, data=00.
  - When locked and w is a token: de=0, cd=token code, data=00.
  - When locked and w is not a token: de=1, data=decoded byte, cd=00.
- Reset values: data=00, cd=00, de=0, locked=0, offset=0, prev=0, state SEARCH, counters 0.
- Reset mid-operation: all of the above are restored on the next clk edge, and lock must be re-acquired.

## Timing
- Pipeline:
  - Stage 1 registers w (from prev, tmds_word and offset) and the token flag.
  - Stage 2 registers data, cd and de.
- Latency: the raw word sampled at edge n appears decoded at the outputs after edge n+2. The FSM acts on the stage-1 result.
- locked rises one cycle after the FSM enters LOCKED, aligned with stage 2. Its first decoded output is the TOKEN_RUN-th token.
- The offset output is the register value and changes the cycle after a slip.
- No backpressure: one output word is produced per clk once the pipeline has filled.

## Structure
- Shared package holds:
  - the four token constants and CD codes,
  - the FSM state enum,
  - default TOKEN_RUN and SLIP_WAIT values.
- Counter widths are $clog2(SLIP_WAIT+1) and $clog2(TOKEN_RUN+1).
- One natural sub-module, tmds_word_decode: combinational token detect plus 8-bit data decode. It is also reusable by the bench.

## Test plan
- Reset: assert reset for 3 cycles with random tmds_word. Expect data=00, cd=00, de=0, locked=0, offset=0.
- Aligned lock: feed 1101010100 continuously. Expect locked=1 and de=0, cd=00, offset=0 on the 8th token's output (edge 10 after start).
- Misaligned lock: SLIP_WAIT=16 with the stream delayed by 3 bits. Expect offset to step 1, 2, 3 at 16-word intervals, then lock with offset=3.
- Data decode after lock:
  - 0100000000 → de=1, data=00.
  - 1000000000 → data=FF.
  - Tokens 0010101011, 0101010100, 1010101011 → cd 01, 10, 11 with de=0.
- Loss of lock: SLIP_WAIT=16. After lock, send 16 words of 0100000000 with no token. Expect locked=0 and de=0 from the next output, offset unchanged. Re-lock after 8 tokens.
- Reset while locked: pulse reset for 1 cycle during data. Expect all outputs 0 and offset 0 the next cycle, and re-lock within TOKEN_RUN+2 cycles of aligned tokens.
